// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder holding NUM_REGS 32-bit registers.
// Register 0 is a read-only ID word. Registers 1..NUM_REGS-1 are read/write.
// Every access phase is stretched by WAIT_STATES cycles.
// Optional feature macro: APB_SLV_PSLVERR_EN.
// - When it is defined, decode errors are reported on pslverr.
// - When it is not defined, erroring transfers are silently ignored.
// In both builds an erroring write is dropped and an erroring read returns 0.
//
// Handshake: a transfer is one setup cycle (sel=1, penable=0), then access
// cycles (sel=1, penable=1) until pready=1. pready is only meaningful while sel
// is held. pslverr is qualified by pready. Dropping sel before pready aborts
// the transfer with no side effects.
module apb_slave_regfile #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned SEL_IDX     = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    // The WAIT state is ACCESS with a non-zero counter, so it is kept as its own state.
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

    state_t         state, state_nxt;
    logic [2:0]     cnt, cnt_nxt;
    logic           write_q, err_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    regs [NUM_REGS];

    logic           sel, setup, addr_err, do_write;
    logic [AW-1:0]  idx;
    logic [31:0]    rd_data;
    logic           unused_psel;

    assign sel   = psel[SEL_IDX];
    assign setup = (state == ST_IDLE) && sel && !penable;
    assign idx   = paddr[AW+1:2];

    // The address is out of range when any bit above the register window is set.
    // The register count is a power of two.
    assign addr_err = (paddr[1:0] != 2'b00) || (paddr[31:AW+2] != '0) ||
                      (pwrite && (idx == '0));

    assign rd_data     = (idx == '0) ? ID_VALUE : regs[idx];
    assign unused_psel = ^psel;

    // Completion is combinational on the held select, so an abort never shows pready.
    assign pready   = (state == ST_ACCESS) && sel;
    assign do_write = pready && write_q && !err_q;

`ifdef APB_SLV_PSLVERR_EN
    assign pslverr = pready && err_q;
`else
    assign pslverr = 1'b0;
`endif

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    cnt_nxt   = 3'(WAIT_STATES);
                    state_nxt = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the transfer attributes and the read data in the setup phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            prdata  <= '0;
        end else if (setup) begin
            write_q <= pwrite;
            err_q   <= addr_err;
            idx_q   <= idx;
            if (!pwrite) begin
                prdata <= addr_err ? 32'h0 : rd_data;
            end
        end
    end

    // Register bank write.
    // Index 0 is never written, because writes to it are decode errors.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[idx_q] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Testbench for apb_slave_regfile.
// Three responders share one APB bus. Each one is selected by a different psel bit:
//   slave 0: NUM_REGS=16, WAIT_STATES=0, SEL_IDX=0
//   slave 1: NUM_REGS=16, WAIT_STATES=2, SEL_IDX=1
//   slave 2: NUM_REGS=8,  WAIT_STATES=3, SEL_IDX=2
// The bench runs directed cases first, then randomized traffic.
// Results are compared against an array-based register model.
`timescale 1ns/1ps
module tb_apb_slave_regfile;

`ifdef APB_SLV_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [3][64];
    logic [31:0] exp_q [$];

    // ---------------- clock / reset / DUTs ----------------
    always #5 hclk = ~hclk;

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(0), .SEL_IDX(0), .ID_VALUE(32'hA5B0_0001)) dut_a (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]));

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(2), .SEL_IDX(1), .ID_VALUE(32'hA5B0_0002)) dut_b (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]));

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(3), .SEL_IDX(2), .ID_VALUE(32'hA5B0_0003)) dut_c (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]));

    // ---------------- reference model ----------------
    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 2 : 3;
    endfunction

    function automatic int nregs_of(input int s);
        return (s == 2) ? 8 : 16;
    endfunction

    function automatic logic [31:0] id_of(input int s);
        return 32'hA5B0_0001 + 32'(s);
    endfunction

    function automatic bit exp_err(input int s, input bit wr, input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= 32'(4 * nregs_of(s))) || (wr && addr < 4);
    endfunction

    function automatic logic [31:0] read_model(input int s, input logic [31:0] addr);
        return (addr / 4 == 0) ? id_of(s) : model[s][addr / 4];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 64; j++) begin
                model[i][j] = 32'h0;
            end
        end
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Every driver is entered just after a rising edge.
    // Every driver leaves just after a rising edge with the bus idle.
    task automatic xfer(input int s, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit idle_after);
        int          cycles;
        bit          err;
        logic [2:0]  stray;
        logic [31:0] exp_rd;
        exp_rd = 32'h0;
        err    = exp_err(s, wr, addr);
        if (!wr) exp_q.push_back(err ? 32'h0 : read_model(s, addr));
        psel = 3'(1 << s); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge hclk);
        stray = pready_v;
        @(posedge hclk); #1;
        penable = 1'b1;
        cycles  = 1;
        forever begin
            @(negedge hclk);
            stray |= pready_v & ~3'(1 << s);
            if (pready_v[s] || cycles >= 20) break;
            @(posedge hclk); #1;
            cycles++;
        end
        check_eq($sformatf("latency s%0d a%0h", s, addr), 32'(cycles), 32'(1 + ws_of(s)));
        check_eq("stray pready", 32'(stray), 32'h0);
        check_eq($sformatf("pslverr s%0d a%0h w%0d", s, addr, wr), 32'(pslverr_v[s]), 32'(ERR_EN && err));
        if (!wr) begin
            exp_rd = exp_q.pop_front();
            check_eq($sformatf("prdata s%0d a%0h", s, addr), prdata_v[s], exp_rd);
        end
        @(posedge hclk); #1;
        if (wr && !err) model[s][addr / 4] = wdata;
        psel = 3'b000; penable = 1'b0;
        if (idle_after) begin
            @(negedge hclk);
            check_eq("pready one cycle", 32'(pready_v), 32'h0);
            check_eq("pslverr idle", 32'(pslverr_v), 32'h0);
            if (!wr) check_eq("prdata hold", prdata_v[s], exp_rd);
            @(posedge hclk); #1;
        end
    endtask

    // Start a write, wait k access cycles (k <= wait states), then drop the select.
    task automatic abort_write(input int s, input logic [31:0] addr,
                               input logic [31:0] wdata, input int k);
        psel = 3'(1 << s); penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wdata;
        @(posedge hclk); #1;
        penable = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge hclk);
            check_eq("abort waiting", 32'(pready_v), 32'h0);
            @(posedge hclk); #1;
        end
        psel = 3'b000; penable = 1'b0;
        @(negedge hclk);
        check_eq("abort no pready", 32'(pready_v), 32'h0);
        @(posedge hclk); #1;
    endtask

    // Hold select and enable high with no setup phase. The slave must not respond.
    task automatic stray_enable(input int s);
        psel = 3'(1 << s); penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            check_eq("enable w/o setup", 32'(pready_v), 32'h0);
            @(posedge hclk); #1;
        end
        psel = 3'b000; penable = 1'b0;
        @(posedge hclk); #1;
    endtask

    function automatic logic [31:0] rand_addr(input int s);
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return $urandom;
            2:       return 32'(4 * nregs_of(s)) + 32'($urandom_range(0, 3) * 4);
            3:       return 32'($urandom_range(0, 4 * nregs_of(s) - 1));
            default: return 32'($urandom_range(0, nregs_of(s) - 1) * 4);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        hreset = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        clear_model();
        repeat (2) @(posedge hclk);
        #1;
        for (int s = 0; s < 3; s++) check_eq($sformatf("reset prdata s%0d", s), prdata_v[s], 32'h0);
        check_eq("reset pready", 32'(pready_v), 32'h0);
        check_eq("reset pslverr", 32'(pslverr_v), 32'h0);
        hreset = 1'b0;
        @(posedge hclk); #1;

        // Zero-wait write/read and ID register.
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 1'b1);
        xfer(0, 1'b0, 32'h04, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h00, 32'h0, 1'b1);

        // Wait states and back-to-back write then read.
        xfer(1, 1'b1, 32'h08, 32'h0BAD_F00D, 1'b0);
        xfer(1, 1'b0, 32'h08, 32'h0, 1'b1);

        // Error responses.
        xfer(0, 1'b1, 32'h06, 32'h1111_1111, 1'b1);
        xfer(0, 1'b0, 32'h04, 32'h0, 1'b1);
        xfer(0, 1'b1, 32'h00, 32'h2222_2222, 1'b1);
        xfer(0, 1'b0, 32'h00, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h40, 32'h0, 1'b1);
        xfer(2, 1'b1, 32'h1C, 32'h7777_0007, 1'b1);
        xfer(2, 1'b0, 32'h1C, 32'h0, 1'b1);
        xfer(2, 1'b0, 32'h20, 32'h0, 1'b1);

        // Abort during wait, then read back.
        xfer(1, 1'b1, 32'h0C, 32'h0000_C0DE, 1'b1);
        abort_write(1, 32'h0C, 32'hFFFF_FFFF, 1);
        abort_write(1, 32'h0C, 32'hEEEE_EEEE, 2);
        xfer(1, 1'b0, 32'h0C, 32'h0, 1'b1);

        // Other-slave select and enable without setup leave slave 0 untouched.
        xfer(1, 1'b1, 32'h04, 32'h1357_9BDF, 1'b1);
        stray_enable(0);
        xfer(0, 1'b0, 32'h04, 32'h0, 1'b1);

        // Asynchronous reset in the middle of a wait on slave 2.
        xfer(2, 1'b1, 32'h08, 32'h0000_1234, 1'b1);
        xfer(2, 1'b0, 32'h08, 32'h0, 1'b1);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h5555_5555;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        @(negedge hclk);
        check_eq("pre-reset wait", 32'(pready_v), 32'h0);
        hreset = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) check_eq($sformatf("mid reset prdata s%0d", s), prdata_v[s], 32'h0);
        check_eq("mid reset pready", 32'(pready_v), 32'h0);
        check_eq("mid reset pslverr", 32'(pslverr_v), 32'h0);
        psel = 3'b000; penable = 1'b0;
        @(posedge hclk); #1;
        hreset = 1'b0;
        clear_model();
        @(posedge hclk); #1;
        xfer(2, 1'b0, 32'h08, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h04, 32'h0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            int s;
            s = $urandom_range(0, 2);
            if (s != 0 && $urandom_range(0, 9) == 0) begin
                abort_write(s, 32'($urandom_range(1, nregs_of(s) - 1) * 4), $urandom,
                            $urandom_range(1, ws_of(s)));
            end else begin
                xfer(s, 1'($urandom_range(0, 1)), rand_addr(s), $urandom, 1'($urandom_range(0, 1)));
            end
        end

        // Final sweep of every register against the model.
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < nregs_of(s); r++) begin
                xfer(s, 1'b0, 32'(r * 4), 32'h0, 1'b0);
            end
        end
        @(posedge hclk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
